// File: rtl/fft_stream_ctrl_pkg.sv
// Shared constants for the FFT stream controller: register map, CTRL/STATUS bit
// positions and AXI response codes.
package fft_stream_ctrl_pkg;

  // Register word indices (byte offset = index * 4); indices from 4 up are scratch.
  localparam int REG_CTRL   = 0;
  localparam int REG_CFG    = 1;
  localparam int REG_LEN    = 2;
  localparam int REG_STATUS = 3;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ENABLE = 1;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_PENDING = 1;

  localparam int LEN_W = 5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/fft_stream_ctrl_axil.sv
// AXI4-Lite slave with the controller register file; exposes the START pulse,
// ENABLE, CFG and the clamped LEN_LOG2 to the streaming logic.
module fft_stream_ctrl_axil
  import fft_stream_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int NUM_REGS = 8,
  parameter int MAX_LOG2 = 16
) (
  input  logic                clk,
  input  logic                srst,
  input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
  input  logic                S_AXI_AWVALID,
  output logic                S_AXI_AWREADY,
  input  logic [DATA_W-1:0]   S_AXI_WDATA,
  input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
  input  logic                S_AXI_WVALID,
  output logic                S_AXI_WREADY,
  output logic [1:0]          S_AXI_BRESP,
  output logic                S_AXI_BVALID,
  input  logic                S_AXI_BREADY,
  input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
  input  logic                S_AXI_ARVALID,
  output logic                S_AXI_ARREADY,
  output logic [DATA_W-1:0]   S_AXI_RDATA,
  output logic [1:0]          S_AXI_RRESP,
  output logic                S_AXI_RVALID,
  input  logic                S_AXI_RREADY,
  input  logic [DATA_W-1:0]   status,
  output logic                start,
  output logic                enable,
  output logic [DATA_W-1:0]   cfg,
  output logic [LEN_W-1:0]    len
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(REG_CTRL);
  localparam logic [IDX_W-1:0] IDX_CFG    = IDX_W'(REG_CFG);
  localparam logic [IDX_W-1:0] IDX_LEN    = IDX_W'(REG_LEN);
  localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(REG_STATUS);

  logic                bvalid_reg, rvalid_reg;
  logic [1:0]          bresp_reg, rresp_reg;
  logic [DATA_W-1:0]   rdata_reg, cfg_reg, rd_word;
  logic                enable_reg;
  logic [LEN_W-1:0]    len_reg, len_in, len_clamped;
  logic [DATA_W-1:0]   mem [0:NUM_REGS-1];
  logic [DATA_W-1:0]   wmask;
  logic [IDX_W-1:0]    wr_idx, rd_idx;
  logic                wr_hs, rd_hs, wr_err, rd_err, wr_ok, wr_scratch;
  logic                unused_addr_bits;

  assign wr_idx = S_AXI_AWADDR[IDX_W+1:2];
  assign rd_idx = S_AXI_ARADDR[IDX_W+1:2];
  // The full word address is range-checked so out-of-map accesses never alias onto real registers.
  assign wr_err = S_AXI_AWADDR[ADDR_W-1:2] >= (ADDR_W-2)'(NUM_REGS);
  assign rd_err = S_AXI_ARADDR[ADDR_W-1:2] >= (ADDR_W-2)'(NUM_REGS);
  assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_reg;
  assign S_AXI_WREADY  = S_AXI_AWREADY;
  assign S_AXI_ARREADY = S_AXI_ARVALID & ~rvalid_reg;
  assign wr_hs = S_AXI_AWREADY;
  assign rd_hs = S_AXI_ARREADY;
  assign wr_ok = wr_hs & ~wr_err;
  assign wr_scratch = wr_ok & !(wr_idx inside {IDX_CTRL, IDX_CFG, IDX_LEN, IDX_STATUS});

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W/8; gi++) begin : g_strb
      assign wmask[gi*8 +: 8] = {8{S_AXI_WSTRB[gi]}};
    end
  endgenerate

  assign len_in      = S_AXI_WSTRB[0] ? S_AXI_WDATA[LEN_W-1:0] : len_reg;
  assign len_clamped = (len_in > LEN_W'(MAX_LOG2)) ? LEN_W'(MAX_LOG2) : len_in;

  always_comb begin
    rd_word = '0;
    case (rd_idx)
      IDX_CTRL:   rd_word = DATA_W'(enable_reg) << CTRL_ENABLE;
      IDX_CFG:    rd_word = cfg_reg;
      IDX_LEN:    rd_word = DATA_W'(len_reg);
      IDX_STATUS: rd_word = status;
      default:    rd_word = mem[rd_idx];
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      bvalid_reg <= 1'b0;
      bresp_reg  <= RESP_OKAY;
      rvalid_reg <= 1'b0;
      rresp_reg  <= RESP_OKAY;
      rdata_reg  <= '0;
      enable_reg <= 1'b0;
      cfg_reg    <= '0;
      len_reg    <= '0;
    end else begin
      if (wr_hs) begin
        bvalid_reg <= 1'b1;
        bresp_reg  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (S_AXI_BREADY) begin
        bvalid_reg <= 1'b0;
      end
      if (wr_ok && wr_idx == IDX_CTRL && S_AXI_WSTRB[0])
        enable_reg <= S_AXI_WDATA[CTRL_ENABLE];
      if (wr_ok && wr_idx == IDX_CFG)
        cfg_reg <= (cfg_reg & ~wmask) | (S_AXI_WDATA & wmask);
      if (wr_ok && wr_idx == IDX_LEN)
        len_reg <= len_clamped;
      if (rd_hs) begin
        rvalid_reg <= 1'b1;
        rresp_reg  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        rdata_reg  <= rd_err ? '0 : rd_word;
      end else if (S_AXI_RREADY) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_scratch)
      mem[wr_idx] <= (mem[wr_idx] & ~wmask) | (S_AXI_WDATA & wmask);
  end

  assign S_AXI_BVALID = bvalid_reg;
  assign S_AXI_BRESP  = bresp_reg;
  assign S_AXI_RVALID = rvalid_reg;
  assign S_AXI_RRESP  = rresp_reg;
  assign S_AXI_RDATA  = rdata_reg;
  assign start  = wr_ok & (wr_idx == IDX_CTRL) & S_AXI_WSTRB[0] & S_AXI_WDATA[CTRL_START];
  assign enable = enable_reg;
  assign cfg    = cfg_reg;
  assign len    = len_reg;

endmodule

// File: rtl/fft_stream_ctrl.sv
// FFT stream controller top: register bank, FFT config-word master and a framed
// sample forwarder that inserts TLAST every 2^LEN_LOG2 samples.
module fft_stream_ctrl
  import fft_stream_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int NUM_REGS = 8,
  parameter int MAX_LOG2 = 16,
  parameter int FCNT_W   = 16
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
  input  logic                S_AXI_AWVALID,
  output logic                S_AXI_AWREADY,
  input  logic [DATA_W-1:0]   S_AXI_WDATA,
  input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
  input  logic                S_AXI_WVALID,
  output logic                S_AXI_WREADY,
  output logic [1:0]          S_AXI_BRESP,
  output logic                S_AXI_BVALID,
  input  logic                S_AXI_BREADY,
  input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
  input  logic                S_AXI_ARVALID,
  output logic                S_AXI_ARREADY,
  output logic [DATA_W-1:0]   S_AXI_RDATA,
  output logic [1:0]          S_AXI_RRESP,
  output logic                S_AXI_RVALID,
  input  logic                S_AXI_RREADY,
  output logic [DATA_W-1:0]   M_AXIS_CFG_TDATA,
  output logic                M_AXIS_CFG_TVALID,
  input  logic                M_AXIS_CFG_TREADY,
  input  logic [DATA_W-1:0]   S_AXIS_TDATA,
  input  logic                S_AXIS_TVALID,
  output logic                S_AXIS_TREADY,
  output logic [DATA_W-1:0]   M_AXIS_TDATA,
  output logic                M_AXIS_TVALID,
  input  logic                M_AXIS_TREADY,
  output logic                M_AXIS_TLAST
);

  localparam logic [MAX_LOG2:0] LIM_ONE = {{MAX_LOG2{1'b0}}, 1'b1};

  logic                start, enable;
  logic [DATA_W-1:0]   cfg, status;
  logic [LEN_W-1:0]    len, len_lat_reg, l_eff;
  logic                cfg_valid_reg;
  logic [DATA_W-1:0]   cfg_data_reg;
  logic [MAX_LOG2-1:0] cnt_reg;
  logic [FCNT_W-1:0]   fcnt_reg;
  logic                m_valid_reg, m_last_reg;
  logic [DATA_W-1:0]   m_data_reg;
  logic [MAX_LOG2:0]   lim;
  logic                last, run, mid_frame, s_ready, s_hs, busy;

  fft_stream_ctrl_axil #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .MAX_LOG2(MAX_LOG2)
  ) u_axil (
    .clk(ACLK), .srst(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .status(status), .start(start), .enable(enable), .cfg(cfg), .len(len)
  );

  // At a frame boundary the live LEN_LOG2 applies; mid-frame the latched copy does.
  assign mid_frame = (cnt_reg != '0);
  assign l_eff     = mid_frame ? len_lat_reg : len;
  assign lim       = (LIM_ONE << l_eff) - LIM_ONE;
  assign last      = ({1'b0, cnt_reg} == lim);
  // Once a frame has started it always runs to completion; ENABLE/pending only gate new frames.
  assign run       = mid_frame | (enable & ~cfg_valid_reg);
  assign s_ready   = run & (~m_valid_reg | M_AXIS_TREADY);
  assign s_hs      = S_AXIS_TVALID & s_ready;
  assign busy      = mid_frame | m_valid_reg;

  assign status = (DATA_W'(fcnt_reg) << (DATA_W - FCNT_W))
                | (DATA_W'(cfg_valid_reg) << STAT_PENDING)
                | (DATA_W'(busy) << STAT_BUSY);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cfg_valid_reg <= 1'b0;
      cfg_data_reg  <= '0;
      cnt_reg       <= '0;
      len_lat_reg   <= '0;
      fcnt_reg      <= '0;
      m_valid_reg   <= 1'b0;
      m_last_reg    <= 1'b0;
      m_data_reg    <= '0;
    end else begin
      if (start && !cfg_valid_reg) begin
        cfg_valid_reg <= 1'b1;
        cfg_data_reg  <= cfg;
      end else if (M_AXIS_CFG_TREADY) begin
        cfg_valid_reg <= 1'b0;
      end
      if (!mid_frame)
        len_lat_reg <= len;
      if (s_hs) begin
        m_valid_reg <= 1'b1;
        m_data_reg  <= S_AXIS_TDATA;
        m_last_reg  <= last;
        if (last) begin
          cnt_reg  <= '0;
          fcnt_reg <= fcnt_reg + FCNT_W'(1);
        end else begin
          cnt_reg <= cnt_reg + MAX_LOG2'(1);
        end
      end else if (M_AXIS_TREADY) begin
        m_valid_reg <= 1'b0;
      end
    end
  end

  assign M_AXIS_CFG_TDATA  = cfg_data_reg;
  assign M_AXIS_CFG_TVALID = cfg_valid_reg;
  assign S_AXIS_TREADY     = s_ready;
  assign M_AXIS_TDATA      = m_data_reg;
  assign M_AXIS_TVALID     = m_valid_reg;
  assign M_AXIS_TLAST      = m_last_reg;

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Directed bench for fft_stream_ctrl: register map, config channel, framing,
// random back-pressure, ENABLE drop mid-frame and reset mid-frame.
module tb_fft_stream_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] S_AXI_AWADDR, S_AXI_WDATA, S_AXI_ARADDR;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_AWVALID, S_AXI_WVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_RREADY;
  logic        S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic [31:0] S_AXI_RDATA;
  logic [31:0] M_AXIS_CFG_TDATA, S_AXIS_TDATA, M_AXIS_TDATA;
  logic        M_AXIS_CFG_TVALID, M_AXIS_CFG_TREADY;
  logic        S_AXIS_TVALID, S_AXIS_TREADY;
  logic        M_AXIS_TVALID, M_AXIS_TREADY, M_AXIS_TLAST;

  int n_checks = 0;
  int n_errors = 0;
  int sink_mode = 0;   // 0 always ready, 1 random, 2 never ready
  int cfg_beats = 0;
  logic [32:0] out_q[$];

  always #5 ACLK = ~ACLK;

  fft_stream_ctrl dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .M_AXIS_CFG_TDATA(M_AXIS_CFG_TDATA), .M_AXIS_CFG_TVALID(M_AXIS_CFG_TVALID),
    .M_AXIS_CFG_TREADY(M_AXIS_CFG_TREADY),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
    .M_AXIS_TLAST(M_AXIS_TLAST)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Sink driver and output/config monitors; handshakes are sampled on the falling edge.
  initial begin
    M_AXIS_TREADY = 1'b0;
    forever begin
      @(posedge ACLK); #1;
      M_AXIS_TREADY = (sink_mode == 0) ? 1'b1 : (sink_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  initial forever begin
    @(negedge ACLK);
    if (M_AXIS_TVALID && M_AXIS_TREADY) out_q.push_back({M_AXIS_TLAST, M_AXIS_TDATA});
    if (M_AXIS_CFG_TVALID && M_AXIS_CFG_TREADY) cfg_beats++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input logic [1:0] exp_resp);
    int n;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    #1;
    n = 0;
    while (!S_AXI_AWREADY && n < 50) begin @(posedge ACLK); #1; n++; end
    if (n >= 50) check({tag, "_aw_timeout"}, 32'(n), 32'd0);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    n = 0;
    while (!S_AXI_BVALID && n < 50) begin @(posedge ACLK); #1; n++; end
    check({tag, "_bresp"}, 32'(S_AXI_BRESP), 32'(exp_resp));
    @(posedge ACLK); #1;
    check({tag, "_bhold"}, 32'(S_AXI_BVALID), 32'd1);
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
    $display("write %s addr=%h data=%h strb=%b resp=%0d", tag, addr, data, strb, S_AXI_BRESP);
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                    input logic [1:0] exp_resp);
    int n;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    #1;
    n = 0;
    while (!S_AXI_ARREADY && n < 50) begin @(posedge ACLK); #1; n++; end
    if (n >= 50) check({tag, "_ar_timeout"}, 32'(n), 32'd0);
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!S_AXI_RVALID && n < 50) begin @(posedge ACLK); #1; n++; end
    check({tag, "_rdata"}, S_AXI_RDATA, exp_data);
    check({tag, "_rresp"}, 32'(S_AXI_RRESP), 32'(exp_resp));
    $display("read  %s addr=%h data=%h resp=%0d", tag, addr, S_AXI_RDATA, S_AXI_RRESP);
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic src(input int n, input logic [31:0] base, input bit rnd);
    int i = 0;
    int cyc = 0;
    bit acc;
    S_AXIS_TVALID = 1'b0;
    while (i < n && cyc < 3000) begin
      if (!S_AXIS_TVALID && (!rnd || $urandom_range(0, 2) != 0)) begin
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA  = base + 32'(i);
      end
      @(negedge ACLK);
      acc = S_AXIS_TVALID & S_AXIS_TREADY;
      @(posedge ACLK); #1;
      cyc++;
      if (acc) begin i++; S_AXIS_TVALID = 1'b0; end
    end
    S_AXIS_TVALID = 1'b0;
    if (i < n) check("src_timeout", 32'(i), 32'(n));
  endtask

  task automatic wait_out(input string tag, input int n);
    int cyc = 0;
    while (out_q.size() < n && cyc < 2000) begin @(posedge ACLK); #1; cyc++; end
    check({tag, "_count"}, 32'(out_q.size()), 32'(n));
  endtask

  task automatic check_frames(input string tag, input logic [31:0] base, input int n, input int period);
    for (int k = 0; k < n && k < out_q.size(); k++) begin
      check($sformatf("%s_data%0d", tag, k), out_q[k][31:0], base + 32'(k));
      check($sformatf("%s_last%0d", tag, k), 32'(out_q[k][32]), 32'(((k + 1) % period) == 0));
      $display("beat  %s #%0d data=%h last=%0d", tag, k, out_q[k][31:0], out_q[k][32]);
    end
    out_q.delete();
  endtask

  initial begin
    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_ARADDR = '0;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    M_AXIS_CFG_TREADY = 1'b0; S_AXIS_TVALID = 1'b0; S_AXIS_TDATA = '0;
    repeat (3) @(posedge ACLK);
    #1;
    ARESET = 1'b0;

    // Reset state
    check("rst_bvalid", 32'(S_AXI_BVALID), 0);
    check("rst_rvalid", 32'(S_AXI_RVALID), 0);
    check("rst_rdata", S_AXI_RDATA, 0);
    check("rst_cfg_tvalid", 32'(M_AXIS_CFG_TVALID), 0);
    check("rst_s_tready", 32'(S_AXIS_TREADY), 0);
    check("rst_m_tvalid", 32'(M_AXIS_TVALID), 0);
    rd("rst_ctrl", 32'h0, 32'h0, 2'b00);
    rd("rst_cfg", 32'h4, 32'h0, 2'b00);
    rd("rst_len", 32'h8, 32'h0, 2'b00);
    rd("rst_status", 32'hC, 32'h0, 2'b00);

    // Scratch registers
    wr("scr0", 32'h10, 32'h0101FFFF, 4'hF, 2'b00);
    wr("scr1", 32'h14, 32'habcd0001, 4'hF, 2'b00);
    wr("scr2", 32'h18, 32'hdead0011, 4'hF, 2'b00);
    wr("scr3", 32'h1C, 32'hbeef0011, 4'hF, 2'b00);
    rd("scr0", 32'h10, 32'h0101FFFF, 2'b00);
    rd("scr1", 32'h14, 32'habcd0001, 2'b00);
    rd("scr2", 32'h18, 32'hdead0011, 2'b00);
    rd("scr3", 32'h1C, 32'hbeef0011, 2'b00);

    // Out-of-range access must not alias onto index 0
    wr("oor", 32'h20, 32'hFFFFFFFF, 4'hF, 2'b10);
    rd("oor", 32'h20, 32'h0, 2'b10);
    rd("oor_ctrl", 32'h0, 32'h0, 2'b00);
    rd("oor_scr0", 32'h10, 32'h0101FFFF, 2'b00);

    // Byte strobes: bytes 0 and 2 replaced in 0xabcd0001
    wr("strb", 32'h14, 32'h11223344, 4'b0101, 2'b00);
    rd("strb", 32'h14, 32'hab220044, 2'b00);

    // LEN clamp and read-only STATUS
    wr("len31", 32'h8, 32'd31, 4'hF, 2'b00);
    rd("len31", 32'h8, 32'd16, 2'b00);
    wr("len5", 32'h8, 32'd5, 4'hF, 2'b00);
    rd("len5", 32'h8, 32'd5, 2'b00);
    wr("status_ro", 32'hC, 32'hFFFFFFFF, 4'hF, 2'b00);
    rd("status_ro", 32'hC, 32'h0, 2'b00);

    // Config channel with back-pressure; a second START while pending is dropped
    wr("cfg", 32'h4, 32'h00000A5B, 4'hF, 2'b00);
    wr("start", 32'h0, 32'h1, 4'hF, 2'b00);
    repeat (5) @(posedge ACLK);
    #1;
    check("cfg_tvalid_held", 32'(M_AXIS_CFG_TVALID), 1);
    check("cfg_tdata", M_AXIS_CFG_TDATA, 32'h00000A5B);
    rd("cfg_pending", 32'hC, 32'h2, 2'b00);
    rd("ctrl_start_rd0", 32'h0, 32'h0, 2'b00);
    wr("start_again", 32'h0, 32'h1, 4'hF, 2'b00);
    check("cfg_beats0", 32'(cfg_beats), 0);
    M_AXIS_CFG_TREADY = 1'b1;
    @(posedge ACLK); #1;
    M_AXIS_CFG_TREADY = 1'b0;
    check("cfg_tvalid_drop", 32'(M_AXIS_CFG_TVALID), 0);
    repeat (3) @(posedge ACLK);
    #1;
    check("cfg_beats1", 32'(cfg_beats), 1);

    // Framing, L=3, sink always ready
    sink_mode = 0;
    wr("len3", 32'h8, 32'd3, 4'hF, 2'b00);
    wr("enable", 32'h0, 32'h2, 4'hF, 2'b00);
    src(16, 32'd1, 1'b0);
    wait_out("frame16", 16);
    check_frames("frame16", 32'd1, 16, 8);
    rd("frame16_status", 32'hC, 32'h00020000, 2'b00);

    // Random back-pressure on both streams
    sink_mode = 1;
    src(64, 32'd100, 1'b1);
    wait_out("rand64", 64);
    check_frames("rand64", 32'd100, 64, 8);
    sink_mode = 0;
    repeat (3) @(posedge ACLK);
    #1;
    rd("rand64_status", 32'hC, 32'h000A0000, 2'b00);

    // ENABLE cleared and LEN changed after sample 3: frame of 8 still completes
    src(3, 32'd1000, 1'b0);
    wr("len1_mid", 32'h8, 32'd1, 4'hF, 2'b00);
    wr("disable_mid", 32'h0, 32'h0, 4'hF, 2'b00);
    src(5, 32'd1003, 1'b0);
    wait_out("dis8", 8);
    check_frames("dis8", 32'd1000, 8, 8);
    S_AXIS_TDATA = 32'd1008; S_AXIS_TVALID = 1'b1;
    repeat (5) @(posedge ACLK);
    #1;
    check("dis_tready", 32'(S_AXIS_TREADY), 0);
    check("dis_no_extra", 32'(out_q.size()), 0);
    S_AXIS_TVALID = 1'b0;

    // New LEN applies at the next frame; then reset mid-frame with held outputs
    wr("reenable", 32'h0, 32'h2, 4'hF, 2'b00);
    src(2, 32'd2000, 1'b0);
    wait_out("l1", 2);
    check_frames("l1", 32'd2000, 2, 2);
    sink_mode = 2;
    @(posedge ACLK); #1;
    src(1, 32'd3000, 1'b0);
    @(posedge ACLK); #1;
    check("held_tvalid", 32'(M_AXIS_TVALID), 1);
    check("held_tdata", M_AXIS_TDATA, 32'd3000);
    check("held_tlast", 32'(M_AXIS_TLAST), 0);
    wr("start_mid", 32'h0, 32'h3, 4'hF, 2'b00);
    check("mid_cfg_tvalid", 32'(M_AXIS_CFG_TVALID), 1);
    rd("mid_status", 32'hC, 32'h000C0003, 2'b00);
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    check("arst_m_tvalid", 32'(M_AXIS_TVALID), 0);
    check("arst_m_tlast", 32'(M_AXIS_TLAST), 0);
    check("arst_s_tready", 32'(S_AXIS_TREADY), 0);
    check("arst_cfg_tvalid", 32'(M_AXIS_CFG_TVALID), 0);
    check("arst_rdata", S_AXI_RDATA, 0);
    ARESET = 1'b0;
    sink_mode = 0;
    rd("arst_status", 32'hC, 32'h0, 2'b00);
    rd("arst_ctrl", 32'h0, 32'h0, 2'b00);
    rd("arst_len", 32'h8, 32'h0, 2'b00);
    rd("arst_cfg", 32'h4, 32'h0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
